// File: rtl/sr_bank_pkg.sv
// Shared types and helpers for the clocked set/reset channel bank.
// Conflict-resolution modes, the sampled {S,R} pair and the per-pair next-state rule.
package sr_bank_pkg;

   typedef enum logic [1:0] {
      SR_RDOM = 2'd0,
      SR_SDOM = 2'd1,
      SR_HOLD = 2'd2,
      SR_TOGL = 2'd3
   } sr_mode_e;

   localparam int unsigned FILT_MAX = 15;
   localparam int unsigned STAB_W   = 4;

   typedef struct packed {
      logic s;
      logic r;
   } pair_t;

   localparam pair_t PAIR_IDLE = '{s: 1'b0, r: 1'b0};

   // Next Q for an accepted pair while the channel gate is open.
   function automatic logic resolve(input sr_mode_e mode, input pair_t p, input logic q);
      logic q_new;
      q_new = q;
      unique case ({p.s, p.r})
         2'b10: q_new = 1'b1;
         2'b01: q_new = 1'b0;
         2'b11: begin
            unique case (mode)
               SR_RDOM: q_new = 1'b0;
               SR_SDOM: q_new = 1'b1;
               SR_HOLD: q_new = q;
               SR_TOGL: q_new = ~q;
               default: q_new = q;
            endcase
         end
         default: q_new = q;
      endcase
      return q_new;
   endfunction

endpackage

// File: rtl/sr_bank_cell.sv
// One set/reset storage channel: input stability filter, accepted pair,
// gated Q/Qbar update, conflict entry detect and sticky conflict flag.
module sr_bank_cell
   import sr_bank_pkg::*;
#(
   parameter sr_mode_e    MODE = SR_RDOM,
   parameter int unsigned FILT = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic s,
   input  logic r,
   input  logic c,
   input  logic clr,
   output logic q,
   output logic qbar,
   output logic conflict,
   output logic entry_c
);

   localparam int unsigned       FILT_EFF = (FILT > FILT_MAX) ? FILT_MAX : FILT;
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(FILT_MAX);
   localparam logic [STAB_W-1:0] STAB_ACC = STAB_W'(FILT_EFF);

   pair_t             raw;
   pair_t             samp;
   pair_t             acc;
   pair_t             acc_now;
   logic [STAB_W-1:0] stab;
   logic [STAB_W-1:0] stab_nxt;
   logic              accept;
   logic              hit;
   logic              hit_prev;
   logic              q_nxt;

   assign raw = '{s: s, r: r};

   // Stability count: number of consecutive prior edges that saw this same pair.
   always_comb begin
      stab_nxt = '0;
      if (raw == samp) begin
         stab_nxt = (stab == STAB_MAX) ? stab : stab + STAB_W'(1);
      end
      accept  = (stab_nxt >= STAB_ACC);
      acc_now = accept ? raw : acc;
   end

   // The pair accepted at this edge acts on this same edge, as a gated latch would.
   always_comb begin
      q_nxt = q;
      if (c) begin
         q_nxt = resolve(MODE, acc_now, q);
      end
      hit     = c & acc_now.s & acc_now.r;
      entry_c = hit & ~hit_prev;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         samp     <= PAIR_IDLE;
         stab     <= '0;
         acc      <= PAIR_IDLE;
         q        <= 1'b0;
         qbar     <= 1'b1;
         hit_prev <= 1'b0;
         conflict <= 1'b0;
      end else begin
         samp     <= raw;
         stab     <= stab_nxt;
         acc      <= acc_now;
         q        <= q_nxt;
         qbar     <= ~q_nxt;
         hit_prev <= hit;
         // A fresh entry outranks a simultaneous clear.
         if (entry_c) begin
            conflict <= 1'b1;
         end else if (clr) begin
            conflict <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sr_latch_bank.sv
// Clocked bank of CH filtered set/reset channels with sticky conflict flags
// and a saturating count of conflict entries across all channels.
module sr_latch_bank
   import sr_bank_pkg::*;
#(
   parameter int unsigned CH    = 8,
   parameter sr_mode_e    MODE  = SR_RDOM,
   parameter int unsigned FILT  = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [CH-1:0]    S,
   input  logic [CH-1:0]    R,
   input  logic [CH-1:0]    C,
   input  logic             conflict_clr,
   output logic [CH-1:0]    Q,
   output logic [CH-1:0]    Qbar,
   output logic [CH-1:0]    conflict,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam int unsigned      POP_W   = $clog2(CH + 1);
   localparam int unsigned      SUM_W   = CNT_W + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

   logic [CH-1:0]    entry_c;
   logic [POP_W-1:0] pop;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt_nxt;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      sr_bank_cell #(
         .MODE (MODE),
         .FILT (FILT)
      ) u_cell (
         .CLK      (CLK),
         .RST      (RST),
         .s        (S[i]),
         .r        (R[i]),
         .c        (C[i]),
         .clr      (conflict_clr),
         .q        (Q[i]),
         .qbar     (Qbar[i]),
         .conflict (conflict[i]),
         .entry_c  (entry_c[i])
      );
   end

   // Number of channels entering a conflict on this edge.
   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         pop = pop + POP_W'(entry_c[i]);
      end
   end

   // One extra bit of headroom makes the saturation test a plain compare.
   always_comb begin
      sum     = SUM_W'(conflict_cnt) + SUM_W'(pop);
      cnt_nxt = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         conflict_cnt <= '0;
      end else begin
         conflict_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Self-checking bench: four banks (one per conflict mode) on shared inputs,
// table-driven vectors plus mode and counter-saturation sequences, scoreboard-checked.
module tb_sr_latch_bank;
   import sr_bank_pkg::*;

   typedef enum int {K_Q, K_QB, K_CONF, K_CNT, K_QS, K_QH, K_QT, K_CNTT} kind_e;

   typedef struct {
      string      name;
      logic       rst;
      logic [7:0] s;
      logic [7:0] r;
      logic [7:0] c;
      logic       clr;
      kind_e      kind;
      logic [7:0] mask;
      logic [7:0] val;
   } vec_t;

   typedef struct {
      string      name;
      int         at;
      kind_e      kind;
      logic [7:0] mask;
      logic [7:0] val;
   } exp_t;

   logic       CLK;
   logic       RST;
   logic [7:0] S, R, C;
   logic       conflict_clr;

   logic [7:0] q_r, qb_r, conf_r, cnt_r;
   logic [7:0] q_s, qb_s, conf_s, cnt_s;
   logic [7:0] q_h, qb_h, conf_h, cnt_h;
   logic [7:0] q_t, qb_t, conf_t;
   logic [1:0] cnt_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   edge_n = 0;
   int   total  = 0;
   int   bad    = 0;

   sr_latch_bank #(.CH(8), .MODE(SR_RDOM), .FILT(2), .CNT_W(8)) dut_r (
      .CLK(CLK), .RST(RST), .S(S), .R(R), .C(C), .conflict_clr(conflict_clr),
      .Q(q_r), .Qbar(qb_r), .conflict(conf_r), .conflict_cnt(cnt_r));
   sr_latch_bank #(.CH(8), .MODE(SR_SDOM), .FILT(2), .CNT_W(8)) dut_s (
      .CLK(CLK), .RST(RST), .S(S), .R(R), .C(C), .conflict_clr(conflict_clr),
      .Q(q_s), .Qbar(qb_s), .conflict(conf_s), .conflict_cnt(cnt_s));
   sr_latch_bank #(.CH(8), .MODE(SR_HOLD), .FILT(2), .CNT_W(8)) dut_h (
      .CLK(CLK), .RST(RST), .S(S), .R(R), .C(C), .conflict_clr(conflict_clr),
      .Q(q_h), .Qbar(qb_h), .conflict(conf_h), .conflict_cnt(cnt_h));
   sr_latch_bank #(.CH(8), .MODE(SR_TOGL), .FILT(2), .CNT_W(2)) dut_t (
      .CLK(CLK), .RST(RST), .S(S), .R(R), .C(C), .conflict_clr(conflict_clr),
      .Q(q_t), .Qbar(qb_t), .conflict(conf_t), .conflict_cnt(cnt_t));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [7:0] actual(input kind_e k);
      case (k)
         K_Q:     return q_r;
         K_QB:    return qb_r;
         K_CONF:  return conf_r;
         K_CNT:   return cnt_r;
         K_QS:    return q_s;
         K_QH:    return q_h;
         K_QT:    return q_t;
         K_CNTT:  return 8'(cnt_t);
         default: return 8'h00;
      endcase
   endfunction

   function automatic void add(input string n, input logic rst, input logic [7:0] s,
                               input logic [7:0] r, input logic [7:0] c, input logic clr,
                               input kind_e k, input logic [7:0] m, input logic [7:0] v);
      tbl.push_back('{n, rst, s, r, c, clr, k, m, v});
   endfunction

   task automatic drive(input logic rst, input logic [7:0] s, input logic [7:0] r,
                        input logic [7:0] c, input logic clr);
      RST = rst; S = s; R = r; C = c; conflict_clr = clr;
   endtask

   task automatic expect_next(input string n, input kind_e k, input logic [7:0] m,
                              input logic [7:0] v);
      sb.push_back('{n, edge_n + 1, k, m, v});
   endtask

   // Advance one edge, then retire every expectation due at that edge.
   task automatic tick();
      exp_t       e;
      logic [7:0] a;
      @(posedge CLK);
      edge_n++;
      #1;
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
         e = sb.pop_front();
         a = actual(e.kind) & e.mask;
         total++;
         if (a !== e.val) begin
            bad++;
            $display("FAIL %s @edge %0d: got %h want %h", e.name, edge_n, a, e.val);
         end
      end
   endtask

   initial begin
      logic [7:0] rd[4];
      logic [7:0] sd[4];
      logic [7:0] hd[4];
      logic [7:0] td[4];
      logic [7:0] sat[5];
      rd  = '{8'h00, 8'h00, 8'h00, 8'h00};
      sd  = '{8'h80, 8'h80, 8'h80, 8'h80};
      hd  = '{8'h80, 8'h80, 8'h80, 8'h80};
      td  = '{8'h00, 8'h80, 8'h00, 8'h80};
      sat = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

      drive(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0);

      // Reset with S asserted, then release and wait out the filter.
      add("rst_q",      1, 8'hFF, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'h00);
      add("rst_qbar",   1, 8'hFF, 8'h00, 8'hFF, 0, K_QB,   8'hFF, 8'hFF);
      add("rst_conf",   1, 8'hFF, 8'h00, 8'hFF, 0, K_CONF, 8'hFF, 8'h00);
      add("rst_cnt",    1, 8'hFF, 8'h00, 8'hFF, 0, K_CNT,  8'hFF, 8'h00);
      add("rel_wait1",  0, 8'hFF, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'h00);
      add("rel_wait2",  0, 8'hFF, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'h00);
      add("rel_accept", 0, 8'hFF, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'hFF);
      add("r_wait1",    0, 8'h00, 8'hFF, 8'hFF, 0, K_QB,   8'hFF, 8'h00);
      add("r_wait2",    0, 8'h00, 8'hFF, 8'hFF, 0, K_Q,    8'hFF, 8'hFF);
      add("r_accept",   0, 8'h00, 8'hFF, 8'hFF, 0, K_Q,    8'hFF, 8'h00);
      // Two-cycle glitch on S[0] is filtered, three-cycle hold is accepted.
      add("glitch1",    0, 8'h01, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'h00);
      add("glitch2",    0, 8'h01, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'h00);
      add("glitch3",    0, 8'h00, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'h00);
      add("glitch4",    0, 8'h00, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'h00);
      add("filt_w1",    0, 8'h01, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'h00);
      add("filt_w2",    0, 8'h01, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'h00);
      add("filt_acc",   0, 8'h01, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'h01);
      // Gate closed on channel 3.
      for (int k = 0; k < 4; k++)
         add("gate_closed", 0, 8'h09, 8'h00, 8'hF7, 0, K_Q, 8'hFF, 8'h01);
      add("gate_rise",  0, 8'h09, 8'h00, 8'hFF, 0, K_Q,    8'hFF, 8'h09);
      for (int k = 0; k < 4; k++)
         add("gate_hold", 0, 8'h01, 8'h08, 8'hF7, 0, K_Q, 8'hFF, 8'h09);
      // Channels 1, 2, 5 enter S=R=1 together.
      add("conf_pre1",  0, 8'h27, 8'h26, 8'hFF, 0, K_CONF, 8'hFF, 8'h00);
      add("conf_pre2",  0, 8'h27, 8'h26, 8'hFF, 0, K_CONF, 8'hFF, 8'h00);
      add("conf_entry", 0, 8'h27, 8'h26, 8'hFF, 0, K_CONF, 8'hFF, 8'h26);
      add("cnt_plus3",  0, 8'h27, 8'h26, 8'hFF, 0, K_CNT,  8'hFF, 8'h03);
      add("rdom_q",     0, 8'h27, 8'h26, 8'hFF, 0, K_Q,    8'hFF, 8'h01);
      for (int k = 0; k < 7; k++)
         add("cnt_hold", 0, 8'h27, 8'h26, 8'hFF, 0, K_CNT, 8'hFF, 8'h03);
      add("gate_drop",  0, 8'h27, 8'h26, 8'hFD, 0, K_CONF, 8'hFF, 8'h26);
      add("clr_vs_set", 0, 8'h27, 8'h26, 8'hFF, 1, K_CONF, 8'hFF, 8'h02);
      add("cnt_reentry",0, 8'h27, 8'h26, 8'hFF, 0, K_CNT,  8'hFF, 8'h04);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].s, tbl[i].r, tbl[i].c, tbl[i].clr);
         if (tbl[i].mask != 8'h00)
            expect_next(tbl[i].name, tbl[i].kind, tbl[i].mask, tbl[i].val);
         tick();
      end

      // Mode sequences on channel 7: force Q=1, then hold an accepted 11.
      drive(1'b1, 8'h00, 8'h00, 8'hFF, 1'b0);
      tick();
      drive(1'b0, 8'h80, 8'h00, 8'hFF, 1'b0);
      tick();
      tick();
      expect_next("mode_set_r", K_Q,  8'h80, 8'h80);
      expect_next("mode_set_t", K_QT, 8'h80, 8'h80);
      tick();
      drive(1'b0, 8'h80, 8'h80, 8'hFF, 1'b0);
      tick();
      expect_next("mode_pre_r", K_Q, 8'h80, 8'h80);
      tick();
      for (int k = 0; k < 4; k++) begin
         expect_next("mode_rdom", K_Q,  8'h80, rd[k]);
         expect_next("mode_sdom", K_QS, 8'h80, sd[k]);
         expect_next("mode_hold", K_QH, 8'h80, hd[k]);
         expect_next("mode_togl", K_QT, 8'h80, td[k]);
         if (k == 0) expect_next("mode_qbar", K_QB, 8'h80, 8'h80);
         tick();
      end

      // Counter saturation: accept 11 behind a closed gate, then pulse the gate.
      drive(1'b1, 8'h00, 8'h00, 8'hFF, 1'b0);
      tick();
      drive(1'b0, 8'h80, 8'h80, 8'h7F, 1'b0);
      tick();
      tick();
      expect_next("sat_idle", K_CNTT, 8'hFF, 8'h00);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 8'h80, 8'h80, 8'hFF, 1'b0);
         expect_next("sat_cnt",  K_CNTT, 8'hFF, sat[k]);
         expect_next("wide_cnt", K_CNT,  8'hFF, 8'(k + 1));
         tick();
         drive(1'b0, 8'h80, 8'h80, 8'h7F, 1'b0);
         tick();
      end

      if (sb.size() != 0) begin
         $display("FAIL scoreboard_leftover: got %0d pending want 0", sb.size());
         bad += sb.size();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
